// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Sequences byte/half/word loads and stores from the datapath onto a
//   single-ported 32-bit data memory with a combinational read path.
//   Sub-word stores use a read-modify-write so that only the addressed
//   lanes of the word change. Lane order is little-endian.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_write         1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_signed        load extension: 1 = sign, 0 = zero
//   req_addr          byte address
//   req_wdata         right-justified store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_error        misaligned, illegal-size or out-of-range request
//   busy              unit is not idle
//   memoryRead        memory read enable
//   memoryWrite       memory write enable (memory writes on next clk edge)
//   memoryAddress     word-aligned byte address
//   memoryWriteData   full word to be written
//   memoryOutData     combinational memory read data
module mem_access_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy,
  output logic        memoryRead,
  output logic        memoryWrite,
  output logic [31:0] memoryAddress,
  output logic [31:0] memoryWriteData,
  input  logic [31:0] memoryOutData
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  localparam logic [31:0] MEM_LIM = 32'(MEM_WORDS);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] wbuf_q;    // word to be written in WR
  logic [1:0]  size_q;
  logic        write_q;
  logic        signed_q;
  logic        err_q;

  // Misalignment, illegal size or word index beyond the memory.
  function automatic logic req_bad(input logic [1:0] sz, input logic [31:0] a);
    logic bad;
    bad = (sz == 2'b11) ||
          (sz == 2'b01 && a[0]) ||
          (sz == 2'b10 && a[1:0] != 2'b00);
    if ({2'b00, a[31:2]} >= MEM_LIM) bad = 1'b1;
    return bad;
  endfunction

  // Select the addressed lane and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic sg);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic        [31:0] r;
    r = w;
    case (sz)
      2'b00: begin
        sh = w >> {off, 3'b000};
        b  = $signed(sh[7:0]);
        r  = sg ? 32'($signed(b)) : {24'h0, sh[7:0]};
      end
      2'b01: begin
        sh = w >> {off[1], 4'b0000};
        h  = $signed(sh[15:0]);
        r  = sg ? 32'($signed(h)) : {16'h0, sh[15:0]};
      end
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane(s) of the old word with store data.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] mask;
    logic [31:0] data;
    case (sz)
      2'b00: begin
        mask = 32'h0000_00FF << {off, 3'b000};
        data = {4{wd[7:0]}};
      end
      2'b01: begin
        mask = 32'h0000_FFFF << {off[1], 4'b0000};
        data = {2{wd[15:0]}};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wd;
      end
    endcase
    return (w & ~mask) | (data & mask);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wbuf_q     <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      err_q      <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            wbuf_q     <= req_wdata;
            size_q     <= req_size;
            write_q    <= req_write;
            signed_q   <= req_signed;
            resp_rdata <= '0;
            err_q      <= req_bad(req_size, req_addr);
            if (req_bad(req_size, req_addr)) state <= RESP;
            else if (!req_write)             state <= RD;
            else if (req_size == 2'b10)      state <= WR;
            else                             state <= RMW_RD;
          end
        end
        RD: begin
          resp_rdata <= load_ext(memoryOutData, size_q, addr_q[1:0], signed_q);
          state      <= RESP;
        end
        RMW_RD: begin
          wbuf_q <= merge(memoryOutData, wdata_q, size_q, addr_q[1:0]);
          state  <= WR;
        end
        WR:      state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic mem_act;
  assign mem_act = (state == RD) || (state == RMW_RD) || (state == WR);

  assign req_ready       = (state == IDLE);
  assign busy            = (state != IDLE);
  assign resp_valid      = (state == RESP);
  assign resp_error      = (state == RESP) && err_q;
  assign memoryRead      = (state == RD) || (state == RMW_RD);
  // Gated by rst so a reset during WR can never commit the store.
  assign memoryWrite     = (state == WR) && !rst;
  assign memoryAddress   = mem_act ? {addr_q[31:2], 2'b00} : 32'h0;
  assign memoryWriteData = (state == WR) ? wbuf_q : 32'h0;

  // write_q is captured for completeness of the latched request; the
  // state already encodes load versus store.
  logic unused_ok;
  assign unused_ok = write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        busy;
  logic        memoryRead;
  logic        memoryWrite;
  logic [31:0] memoryAddress;
  logic [31:0] memoryWriteData;
  logic [31:0] memoryOutData;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .busy(busy), .memoryRead(memoryRead),
    .memoryWrite(memoryWrite), .memoryAddress(memoryAddress),
    .memoryWriteData(memoryWriteData), .memoryOutData(memoryOutData)
  );

  // Attached memory model: combinational read, write on rising edge.
  logic [31:0] mem [0:31];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_idx = 5'd0;
  logic [31:0] pre_data = 32'h0;

  assign memoryOutData = (memoryAddress[31:7] == 25'h0) ? mem[memoryAddress[6:2]] : 32'h0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (memoryWrite && memoryAddress[31:7] == 25'h0) mem[memoryAddress[6:2]] <= memoryWriteData;
  end

  task automatic preload(input logic [4:0] idx, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Issue one request and observe it until resp_valid (bounded).
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er,
                         output int nrd, output int nwr, output int rdat, output int wrat);
    lat = -1; rd = 32'hx; er = 1'bx; nrd = 0; nwr = 0; rdat = -1; wrat = -1;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (memoryRead)  begin nrd++; rdat = n; end
      if (memoryWrite) begin nwr++; wrat = n; end
      if (resp_valid) begin
        lat = n; rd = resp_rdata; er = resp_error;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    tests++; if (resp_error !== 1'b0) begin fails++; $display("FAIL reset_resp_error got %b want 0", resp_error); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    tests++; if (memoryRead !== 1'b0 || memoryWrite !== 1'b0) begin fails++; $display("FAIL reset_mem_en got rd=%b wr=%b want 0/0", memoryRead, memoryWrite); end
    tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_load_word();
    int lat, nrd, nwr, rdat, wrat; logic [31:0] rd; logic er;
    preload(5'd9, 32'd100);
    run_req(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, lat, rd, er, nrd, nwr, rdat, wrat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL ldw_latency got %0d want 2", lat); end
    tests++; if (rd !== 32'd100) begin fails++; $display("FAIL ldw_rdata got %h want %h", rd, 32'd100); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL ldw_error got %b want 0", er); end
    tests++; if (nrd !== 1 || nwr !== 0) begin fails++; $display("FAIL ldw_mem_pulses got rd=%0d wr=%0d want 1/0", nrd, nwr); end
    @(negedge clk);
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL ldw_resp_one_cycle got %b want 0", resp_valid); end
  endtask

  task automatic test_load_ext();
    int lat, nrd, nwr, rdat, wrat; logic [31:0] rd; logic er;
    logic [1:0]  sz [5]  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    logic        sg [5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad [5]  = '{32'h25, 32'h24, 32'h24, 32'h24, 32'h27};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF, 32'h0000_00FF, 32'h0};
    preload(5'd9, 32'h0000_80FF);
    for (int i = 0; i < 5; i++) begin
      run_req(1'b0, sz[i], sg[i], ad[i], 32'h0, lat, rd, er, nrd, nwr, rdat, wrat);
      tests++; if (rd !== exp[i] || lat !== 2 || er !== 1'b0) begin
        fails++; $display("FAIL ldext_%0d got rdata=%h lat=%0d err=%b want %h/2/0", i, rd, lat, er, exp[i]);
      end
    end
  endtask

  task automatic test_store();
    int lat, nrd, nwr, rdat, wrat; logic [31:0] rd; logic er;
    preload(5'd9, 32'h1122_3344);
    run_req(1'b1, 2'b00, 1'b0, 32'h26, 32'h0000_00AB, lat, rd, er, nrd, nwr, rdat, wrat);
    tests++; if (lat !== 3) begin fails++; $display("FAIL stb_latency got %0d want 3", lat); end
    tests++; if (rdat !== 1 || wrat !== 2 || nrd !== 1 || nwr !== 1) begin
      fails++; $display("FAIL stb_rmw_order got rd@%0d wr@%0d n=%0d/%0d want 1/2 1/1", rdat, wrat, nrd, nwr); end
    tests++; if (mem[9] !== 32'h11AB_3344) begin fails++; $display("FAIL stb_mem got %h want 11ab3344", mem[9]); end
    tests++; if (rd !== 32'h0 || er !== 1'b0) begin fails++; $display("FAIL stb_resp got %h/%b want 0/0", rd, er); end
    run_req(1'b1, 2'b01, 1'b0, 32'h24, 32'hFFFF_5566, lat, rd, er, nrd, nwr, rdat, wrat);
    tests++; if (mem[9] !== 32'h11AB_5566 || lat !== 3) begin fails++; $display("FAIL sth0 got %h lat=%0d want 11ab5566/3", mem[9], lat); end
    run_req(1'b1, 2'b01, 1'b0, 32'h26, 32'h0000_7788, lat, rd, er, nrd, nwr, rdat, wrat);
    tests++; if (mem[9] !== 32'h7788_5566) begin fails++; $display("FAIL sth2 got %h want 77885566", mem[9]); end
    run_req(1'b1, 2'b10, 1'b0, 32'h28, 32'hCAFE_BABE, lat, rd, er, nrd, nwr, rdat, wrat);
    tests++; if (mem[10] !== 32'hCAFE_BABE || lat !== 2 || nrd !== 0 || wrat !== 1) begin
      fails++; $display("FAIL stw got %h lat=%0d nrd=%0d wr@%0d want cafebabe/2/0/1", mem[10], lat, nrd, wrat); end
  endtask

  task automatic test_errors();
    int lat, nrd, nwr, rdat, wrat; logic [31:0] rd; logic er;
    logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] ad [4] = '{32'h22, 32'h21, 32'h24, 32'h80};
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, sz[i], 1'b0, ad[i], 32'h0, lat, rd, er, nrd, nwr, rdat, wrat);
      tests++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nrd !== 0 || nwr !== 0) begin
        fails++; $display("FAIL err_%0d got lat=%0d err=%b rdata=%h rd=%0d wr=%0d want 1/1/0/0/0", i, lat, er, rd, nrd, nwr);
      end
    end
    // an erroneous store must not touch memory either
    run_req(1'b1, 2'b01, 1'b0, 32'h27, 32'h1234, lat, rd, er, nrd, nwr, rdat, wrat);
    tests++; if (lat !== 1 || er !== 1'b1 || nwr !== 0 || mem[9] !== 32'h7788_5566) begin
      fails++; $display("FAIL err_store got lat=%0d err=%b wr=%0d mem=%h want 1/1/0/77885566", lat, er, nwr, mem[9]); end
  endtask

  task automatic abort_req(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                           output logic wr_seen, output logic rv_seen);
    wr_seen = 1'b0; rv_seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = sz; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    if (memoryWrite) wr_seen = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (memoryWrite) wr_seen = 1'b1;
      if (resp_valid)  rv_seen = 1'b1;
      if (n == 0) begin
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL abort_ready got %b want 1", req_ready); end
      end
    end
  endtask

  task automatic test_reset_midop();
    logic wr_seen, rv_seen;
    preload(5'd2, 32'h0102_0304);
    abort_req(2'b10, 32'h08, 32'hDEAD_BEEF, wr_seen, rv_seen);
    tests++; if (mem[2] !== 32'h0102_0304 || wr_seen || rv_seen) begin
      fails++; $display("FAIL abort_wr got mem=%h wr=%b rv=%b want 01020304/0/0", mem[2], wr_seen, rv_seen); end
    abort_req(2'b00, 32'h09, 32'h55, wr_seen, rv_seen);
    tests++; if (mem[2] !== 32'h0102_0304 || wr_seen || rv_seen) begin
      fails++; $display("FAIL abort_rmw got mem=%h wr=%b rv=%b want 01020304/0/0", mem[2], wr_seen, rv_seen); end
  endtask

  task automatic test_back_to_back();
    int wr_at [$]; int rv_at [$]; int merged = 0; logic prev_wr = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'h1111_1111;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (memoryWrite) wr_at.push_back(n);
      if (memoryWrite && prev_wr) merged++;
      prev_wr = memoryWrite;
      if (resp_valid) rv_at.push_back(n);
      if (n == 1) begin req_addr = 32'h34; req_wdata = 32'h2222_2222; end
      if (n == 4) req_valid = 1'b0;
    end
    tests++; if (wr_at.size() != 2 || merged != 0) begin
      fails++; $display("FAIL b2b_write_pulses got n=%0d merged=%0d want 2/0", wr_at.size(), merged);
    end else if (wr_at[0] != 1 || wr_at[1] != 4) begin
      fails++; $display("FAIL b2b_write_pulses got at %0d,%0d want 1,4", wr_at[0], wr_at[1]);
    end
    tests++; if (rv_at.size() != 2) begin
      fails++; $display("FAIL b2b_resp got n=%0d want 2", rv_at.size());
    end else if (rv_at[0] != 2 || rv_at[1] != 5) begin
      fails++; $display("FAIL b2b_resp got at %0d,%0d want 2,5", rv_at[0], rv_at[1]);
    end
    tests++; if (mem[12] !== 32'h1111_1111 || mem[13] !== 32'h2222_2222) begin
      fails++; $display("FAIL b2b_mem got %h %h want 11111111 22222222", mem[12], mem[13]); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    test_reset();
    test_load_word();
    test_load_ext();
    test_store();
    test_errors();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
